// File: rtl/seven_seg_scan.sv
// seven_seg_scan: multiplexed N-digit seven-segment scanner (ports: clk, rst, en, nums, points, blank_mask, blink_mask -> seg, an, frame_tick, blink_phase)
module seven_seg_scan #(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD         = 2,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   nums,
  input  logic [DIGITS-1:0]     points,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick,
  output logic                  blink_phase
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [IW-1:0]     r_idx;
  logic [CW-1:0]     r_cnt;
  logic [FW-1:0]     r_fcnt;
  logic              r_blink;
  logic              r_wrapped;
  logic [7:0]        r_seg;
  logic [DIGITS-1:0] r_an;
  logic              r_tick;
  logic              w_slot_end;
  logic              w_wrap;
  logic              w_last_frame;
  logic              w_dead;
  logic              w_dark;
  logic              w_dp;
  logic [3:0]        w_code;
  logic [6:0]        w_glyph;
  assign w_slot_end   = r_cnt == CW'(SCAN_DIV - 1);
  assign w_wrap       = w_slot_end && r_idx == IW'(DIGITS - 1);
  assign w_last_frame = r_fcnt == FW'(BLINK_FRAMES - 1);
  assign w_dead       = 32'(r_cnt) < DEAD;
  assign w_code       = nums[4*r_idx +: 4];
  assign w_dark       = blank_mask[r_idx] | (blink_mask[r_idx] & r_blink);
  assign w_dp         = (w_code == 4'hF) | ~points[r_idx];
  always_comb begin
    w_glyph = 7'b1111111;
    case (w_code)
      4'h0: w_glyph = 7'b1000000;
      4'h1: w_glyph = 7'b1111001;
      4'h2: w_glyph = 7'b0100100;
      4'h3: w_glyph = 7'b0110000;
      4'h4: w_glyph = 7'b0011001;
      4'h5: w_glyph = 7'b0010010;
      4'h6: w_glyph = 7'b0000010;
      4'h7: w_glyph = 7'b1111000;
      4'h8: w_glyph = 7'b0000000;
      4'h9: w_glyph = 7'b0010000;
      4'hA: w_glyph = 7'b0001001;
      4'hB: w_glyph = 7'b0000110;
      4'hC: w_glyph = 7'b1000111;
      4'hD: w_glyph = 7'b1000000;
      4'hE: w_glyph = 7'b0111111;
      default: w_glyph = 7'b1111111;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= '0;
      r_cnt     <= '0;
      r_fcnt    <= '0;
      r_blink   <= 1'b0;
      r_wrapped <= 1'b0;
      r_seg     <= 8'hFF;
      r_an      <= '1;
      r_tick    <= 1'b0;
    end else begin
      // the wrap is remembered so the pulse lines up with the first slot-0 output, even across a pause
      r_tick <= en & r_wrapped;
      r_an   <= (!en || w_dead) ? '1 : ~(DIGITS'(1) << r_idx);
      r_seg  <= (!en || w_dead || w_dark) ? 8'hFF : {w_dp, w_glyph};
      if (en) begin
        r_wrapped <= w_wrap;
        r_cnt     <= w_slot_end ? '0 : r_cnt + 1'b1;
        if (w_slot_end) r_idx <= w_wrap ? '0 : r_idx + 1'b1;
        if (w_wrap) begin
          r_fcnt <= w_last_frame ? '0 : r_fcnt + 1'b1;
          if (w_last_frame) r_blink <= ~r_blink;
        end
      end
    end
  end
  assign seg         = r_seg;
  assign an          = r_an;
  assign frame_tick  = r_tick;
  assign blink_phase = r_blink;
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: directed self-checking bench for seven_seg_scan (DIGITS=4, SCAN_DIV=8, DEAD=2, BLINK_FRAMES=2)
module tb_seven_seg_scan;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] nums = 16'h4321;
  logic [3:0]  points = 4'b0000;
  logic [3:0]  blank_mask = 4'b0000;
  logic [3:0]  blink_mask = 4'b0000;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;
  logic        blink_phase;
  int          checks = 0;
  int          failures = 0;
  int          k = 0;
  logic [3:0]  an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [7:0]  seg_tab [4] = '{8'hF9, 8'hA4, 8'hB0, 8'h99};

  seven_seg_scan #(.DIGITS(4), .SCAN_DIV(8), .DEAD(2), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .en(en), .nums(nums), .points(points),
    .blank_mask(blank_mask), .blink_mask(blink_mask),
    .seg(seg), .an(an), .frame_tick(frame_tick), .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic goto(input int e);
    while (k < e) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] ea, input logic [7:0] es);
    chk({tag, "_an"}, 32'(an), 32'(ea));
    chk({tag, "_seg"}, 32'(seg), 32'(es));
  endtask

  // reset release, then the first frame and the frame_tick on edge 33
  task automatic first_frame();
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    k = 0;
    for (int e = 1; e <= 32; e++) begin
      goto(e);
      if ((e - 1) % 8 < 2) chk_out("dead", 4'hF, 8'hFF);
      else chk_out("slot", an_tab[(e - 1) / 8], seg_tab[(e - 1) / 8]);
      chk("tick_low", 32'(frame_tick), 0);
      chk("phase_f1", 32'(blink_phase), 0);
    end
    goto(33);
    chk("tick_33", 32'(frame_tick), 1);
    chk_out("wrap_dead", 4'hF, 8'hFF);
    goto(34);
    chk("tick_34", 32'(frame_tick), 0);
  endtask

  initial begin
    @(negedge clk);
    chk_out("reset", 4'hF, 8'hFF);
    chk("reset_tick", 32'(frame_tick), 0);
    chk("reset_phase", 32'(blink_phase), 0);
    first_frame();
    nums = 16'h432A;
    points = 4'b0001;
    goto(35);
    chk_out("h_dp", 4'b1110, 8'h09);
    nums = 16'h432F;
    goto(36);
    chk_out("blank_code", 4'b1110, 8'hFF);
    nums = 16'h4321;
    points = 4'b0000;
    blank_mask = 4'b0100;
    goto(43);
    chk_out("f2_s1", 4'b1101, 8'hA4);
    goto(51);
    chk_out("f2_blank", 4'b1011, 8'hFF);
    goto(59);
    chk_out("f2_s3", 4'b0111, 8'h99);
    blink_mask = 4'b0001;
    goto(63);
    chk("phase_63", 32'(blink_phase), 0);
    goto(64);
    chk("phase_64", 32'(blink_phase), 1);
    goto(65);
    chk("tick_65", 32'(frame_tick), 1);
    goto(67);
    chk_out("f3_blink", 4'b1110, 8'hFF);
    goto(75);
    chk_out("f3_s1", 4'b1101, 8'hA4);
    goto(83);
    chk_out("f3_blank", 4'b1011, 8'hFF);
    goto(96);
    chk("phase_96", 32'(blink_phase), 1);
    blank_mask = 4'b0000;
    goto(99);
    chk_out("f4_blink", 4'b1110, 8'hFF);
    goto(107);
    chk_out("f4_s1", 4'b1101, 8'hA4);
    goto(115);
    chk_out("f4_unblank", 4'b1011, 8'hB0);
    goto(127);
    chk("phase_127", 32'(blink_phase), 1);
    goto(128);
    chk("phase_128", 32'(blink_phase), 0);
    goto(131);
    chk_out("f5_unblink", 4'b1110, 8'hF9);
    blink_mask = 4'b0000;
    goto(141);
    chk_out("f5_s1_c4", 4'b1101, 8'hA4);
    en = 1'b0;
    for (int e = 142; e <= 151; e++) begin
      goto(e);
      chk_out("paused", 4'hF, 8'hFF);
      chk("paused_tick", 32'(frame_tick), 0);
    end
    en = 1'b1;
    goto(152);
    chk_out("resume_c5", 4'b1101, 8'hA4);
    goto(154);
    chk_out("resume_c7", 4'b1101, 8'hA4);
    goto(155);
    chk_out("resume_s2_dead", 4'hF, 8'hFF);
    goto(157);
    chk_out("resume_s2", 4'b1011, 8'hB0);
    goto(170);
    chk("tick_170", 32'(frame_tick), 0);
    goto(171);
    chk("tick_171", 32'(frame_tick), 1);
    goto(202);
    chk("phase_202", 32'(blink_phase), 1);
    goto(230);
    chk_out("f7_s3", 4'b0111, 8'h99);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 4'hF, 8'hFF);
    chk("async_rst_phase", 32'(blink_phase), 0);
    chk("async_rst_tick", 32'(frame_tick), 0);
    @(posedge clk);
    @(posedge clk);
    first_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
Parametrised multiplexed N-digit seven-segment display controller.
- Time-multiplexes DIGITS 4-bit glyph codes onto one shared active-low segment bus and an active-low digit-select bus.
- Adds per-digit decimal point, per-digit blanking and per-digit blinking.
- Adds anti-ghosting dead time between digits.
- Sits between the clock/time logic and the board display pins.

Parameters:
DIGITS, 8, number of digits scanned (1..16)
SCAN_DIV, 50000, clk cycles each digit is held, including dead time (must be > DEAD+1)
DEAD, 2, cycles at the start of each digit slot with all anodes off (0 disables)
BLINK_FRAMES, 250, full scan frames per blink half-period (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
en  input  1  display enable; 0 turns the display dark and holds scanning
nums  input  4*DIGITS  glyph codes; digit i = nums[4*i+3:4*i]; digit 0 is rightmost
points  input  DIGITS  decimal point request per digit, 1 = lit
blank_mask  input  DIGITS  1 = digit never lit
blink_mask  input  DIGITS  1 = digit dark during the blink-off phase
seg  output  8  segments, active-low; bit7 = dp, bits6..0 = g,f,e,d,c,b,a
an  output  DIGITS  digit select, active-low, at most one bit low
frame_tick  output  1  one-cycle pulse when the scan wraps from DIGITS-1 to 0
blink_phase  output  1  0 = blink-on phase, 1 = blink-off phase

Behaviour:
- Reset (asynchronous, active-high) sets:
  - seg=8'hFF, an=all ones, frame_tick=0, blink_phase=0.
  - digit index idx=0, slot counter cnt=0, frame counter fcnt=0.
- Glyph decode, active-low, bits 6..0:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10 H=0001001, 11 E=0000110, 12 L=1000111, 13 O=1000000
  - 14 '-'=0111111, 15 blank=1111111
- Decimal point:
  - seg[7]=~points[idx] for codes 0..14, including letters.
  - Code 15 forces seg[7]=1.
- Slot counter, while en=1:
  - cnt increments each cycle, 0..SCAN_DIV-1.
  - When cnt=SCAN_DIV-1: cnt->0 and idx->idx+1.
  - idx wraps DIGITS-1 -> 0.
- frame_tick:
  - Asserted for exactly one cycle.
  - Its cycle is the cycle after idx wraps to 0, aligned with an/seg first reflecting slot 0.
- Blink:
  - fcnt counts frame wraps; on reaching BLINK_FRAMES-1 at a wrap, fcnt->0 and blink_phase toggles.
  - Toggles only at frame boundaries.
- Output registers update every cycle from the current (idx, cnt, inputs); latency = 1 cycle.
  - If cnt<DEAD: an=all ones, seg=8'hFF.
  - Else if blank_mask[idx], or (blink_mask[idx] and blink_phase=1): an=~(1<<idx), seg=8'hFF.
  - Else: an=~(1<<idx), seg={dp, glyph}.
- Inputs are not snapshotted: a nums change mid-slot appears on seg one cycle later.
- en=0:
  - Next cycle an=all ones, seg=8'hFF, frame_tick=0.
  - cnt, idx, fcnt and blink_phase hold.
  - Re-enabling resumes from the held state.
- DIGITS=1: idx stays 0; frame_tick pulses once per slot.
- Reset asserted mid-slot: all state returns to reset values immediately, with no clock needed.

Test Plan:
(DIGITS=4, SCAN_DIV=8, DEAD=2, BLINK_FRAMES=2 unless noted)
- Reset then release, en=1, nums=16'h4321, points=0:
  - an=1111 for 2 cycles, then 1110 with seg=8'hF9 for 6 cycles.
  - Then 1101/8'hA4, 1011/8'hB0, 0111/8'h99.
  - frame_tick pulses on the 33rd cycle after release.
- nums digit0=10 (H), points[0]=1 -> seg=8'h09 during slot 0; digit0=15 with points[0]=1 -> seg=8'hFF.
- blank_mask=4'b0100 -> slot 2 shows an=1011, seg=8'hFF every frame; other slots decode normally.
- blink_mask=4'b0001, 4 frames:
  - blink_phase toggles at frame ends 2 and 4.
  - Slot 0 seg=8'hFF only while blink_phase=1.
- en dropped mid-slot 1 at cnt=5 for 10 cycles:
  - an=1111, seg=8'hFF, no frame_tick.
  - After re-enable, slot 1 resumes at cnt=5 and ends 3 cycles later.
- rst pulsed mid-slot 3 between clock edges -> seg=8'hFF, an=1111, blink_phase=0 immediately; restart identical to the first scenario.
